// File: rtl/text_string_writer.sv
// Character-at-a-time string builder with cursor, BS/CR/FF editing and a clear sweep.
// Optional feature macro SCROLL_EN: a printable character that arrives while full scrolls the string left.
module text_string_writer #(
    parameter int          NCHAR      = 8,
    parameter int          NCHAR_BITS = 3,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic                    vclock,
    input  logic                    reset_n,
    input  logic [7:0]              char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic                    clear,
    output logic [NCHAR*8-1:0]      cstring,
    output logic [NCHAR_BITS:0]     cursor,
    output logic                    full,
    output logic                    busy,
    output logic                    overflow
);

    localparam logic [7:0]          CODE_BS  = 8'h08;
    localparam logic [7:0]          CODE_CR  = 8'h0D;
    localparam logic [7:0]          CODE_FF  = 8'h0C;
    localparam logic [NCHAR_BITS:0] CUR_MAX  = (NCHAR_BITS+1)'(NCHAR);
    localparam logic [NCHAR_BITS:0] CUR_ONE  = (NCHAR_BITS+1)'(1);
    localparam logic [NCHAR_BITS:0] CUR_ZERO = (NCHAR_BITS+1)'(0);
    localparam logic [NCHAR_BITS-1:0] IDX_LAST = NCHAR_BITS'(NCHAR-1);
    localparam logic [NCHAR_BITS-1:0] IDX_ONE  = NCHAR_BITS'(1);
    localparam logic [NCHAR_BITS-1:0] IDX_ZERO = NCHAR_BITS'(0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 state_r;
    logic [7:0]             mem_r [NCHAR];
    logic [NCHAR_BITS:0]    cursor_r;
    logic [NCHAR_BITS-1:0]  clr_idx_r;
    logic                   overflow_r;
    logic [NCHAR_BITS:0]    cursor_dec_s;
    logic                   full_s;

    assign cursor_dec_s = cursor_r - CUR_ONE;
    assign full_s       = (cursor_r == CUR_MAX);
    assign char_ready   = (state_r == ST_IDLE) & ~clear;
    assign cursor       = cursor_r;
    assign full         = full_s;
    assign busy         = (state_r == ST_CLEAR);
    assign overflow     = overflow_r;

    // Position 0 occupies the most significant byte of cstring.
    for (genvar p = 0; p < NCHAR; p++) begin : g_pack
        assign cstring[(NCHAR-1-p)*8 +: 8] = mem_r[p];
    end

    // Editing state machine: handshake decode in IDLE, one blank per cycle in CLEAR.
    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            for (int i = 0; i < NCHAR; i++) begin
                mem_r[i] <= BLANK;
            end
            cursor_r   <= CUR_ZERO;
            clr_idx_r  <= IDX_ZERO;
            overflow_r <= 1'b0;
            state_r    <= ST_IDLE;
        end else begin
            overflow_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clear) begin
                        // A character presented alongside clear is not accepted.
                        state_r   <= ST_CLEAR;
                        clr_idx_r <= IDX_ZERO;
                    end else if (char_valid) begin
                        case (char_in)
                            CODE_BS: begin
                                if (cursor_r != CUR_ZERO) begin
                                    cursor_r <= cursor_dec_s;
                                    mem_r[cursor_dec_s[NCHAR_BITS-1:0]] <= BLANK;
                                end
                            end
                            CODE_CR: begin
                                cursor_r <= CUR_ZERO;
                            end
                            CODE_FF: begin
                                state_r   <= ST_CLEAR;
                                clr_idx_r <= IDX_ZERO;
                            end
                            default: begin
                                if (!full_s) begin
                                    mem_r[cursor_r[NCHAR_BITS-1:0]] <= char_in;
                                    cursor_r <= cursor_r + CUR_ONE;
                                end else begin
`ifdef SCROLL_EN
                                    for (int i = 0; i < NCHAR-1; i++) begin
                                        mem_r[i] <= mem_r[i+1];
                                    end
                                    mem_r[NCHAR-1] <= char_in;
`else
                                    overflow_r <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    mem_r[clr_idx_r] <= BLANK;
                    if (clr_idx_r == IDX_LAST) begin
                        state_r  <= ST_IDLE;
                        cursor_r <= CUR_ZERO;
                    end else begin
                        clr_idx_r <= clr_idx_r + IDX_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
